// File: rtl/trap_arbiter.sv
// Commit-stage trap arbiter: synchronises the interrupt lines, resolves the highest-priority
// interrupt / exception / xRET and hands one trap to the CSR unit followed by a one-cycle flush.
module trap_arbiter #(
    parameter int XLEN      = 64,
    parameter bit HAS_SMODE = 1'b1,
    parameter int IRQ_SYNC  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid_i,
    input  logic [14:0]     commit_exc_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic [XLEN-1:0] commit_tval_i,
    input  logic [1:0]      priv_i,
    input  logic            mstatus_mie_i,
    input  logic            mstatus_sie_i,
    input  logic [11:0]     mie_i,
    input  logic [11:0]     mideleg_i,
    input  logic [15:0]     medeleg_i,
    input  logic [11:0]     mip_sw_i,
    input  logic            irq_mext_i,
    input  logic            irq_msw_i,
    input  logic            irq_mtimer_i,
    output logic [11:0]     mip_o,
    output logic            stall_o,
    output logic            trap_valid_o,
    input  logic            trap_ready_i,
    output logic [1:0]      trap_kind_o,
    output logic [3:0]      trap_cause_o,
    output logic [XLEN-1:0] trap_tval_o,
    output logic [XLEN-1:0] trap_epc_o,
    output logic [1:0]      trap_priv_o,
    output logic            flush_o
);

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [1:0] KIND_EXC  = 2'd0;
    localparam logic [1:0] KIND_IRQ  = 2'd1;
    localparam logic [1:0] KIND_XRET = 2'd2;

    localparam int EXC_FETCH_AF  = 14;
    localparam int EXC_FETCH_PF  = 13;
    localparam int EXC_LOAD_AF   = 12;
    localparam int EXC_LOAD_PF   = 11;
    localparam int EXC_STORE_AF  = 10;
    localparam int EXC_STORE_PF  = 9;
    localparam int EXC_FETCH_MIS = 8;
    localparam int EXC_LOAD_MIS  = 7;
    localparam int EXC_STORE_MIS = 6;
    localparam int EXC_ECALL     = 5;
    localparam int EXC_MRET      = 4;
    localparam int EXC_SRET      = 3;
    localparam int EXC_URET      = 2;
    localparam int EXC_ILLEGAL   = 1;
    localparam int EXC_BKPT      = 0;

    // Lowest priority at index 0; a later hit in the scan overrides an earlier one.
    localparam logic [5:0][3:0] IRQ_ORDER = {4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic irq_takeable(input logic       pend,
                                          input logic       deleg,
                                          input logic [1:0] priv,
                                          input logic       m_en,
                                          input logic       s_en);
        logic ok;
        if (deleg) begin
            ok = (priv == PRIV_U) || ((priv == PRIV_S) && s_en);
        end else begin
            ok = (priv != PRIV_M) || m_en;
        end
        return pend && ok;
    endfunction

    state_t                 state_r, state_s;
    logic [IRQ_SYNC-1:0][2:0] sync_r;
    logic [11:0]            mip_s;
    logic [11:0]            pend_s;
    logic                   irq_hit_s;
    logic [3:0]             irq_cause_s;
    logic                   ill_s;
    logic                   mret_ok_s;
    logic                   sret_ok_s;
    logic                   exc_hit_s;
    logic [3:0]             exc_cause_s;
    logic [XLEN-1:0]        exc_tval_s;
    logic                   ev_s;
    logic [1:0]             ev_kind_s;
    logic [3:0]             ev_cause_s;
    logic [XLEN-1:0]        ev_tval_s;
    logic [1:0]             ev_priv_s;
    logic                   latch_s;
    logic                   stall_s;
    logic                   trap_valid_r;
    logic                   flush_r;
    logic [1:0]             kind_r;
    logic [3:0]             cause_r;
    logic [XLEN-1:0]        tval_r;
    logic [XLEN-1:0]        epc_r;
    logic [1:0]             priv_r;
    logic                   unused_s;

    // Synchroniser chain, one {mext, mtimer, msw} triple per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= {irq_mext_i, irq_mtimer_i, irq_msw_i};
            for (int i = 1; i < IRQ_SYNC; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Merge synchronised machine lines with the software-writable supervisor bits.
    always_comb begin
        mip_s     = 12'd0;
        mip_s[11] = sync_r[IRQ_SYNC-1][2];
        mip_s[7]  = sync_r[IRQ_SYNC-1][1];
        mip_s[3]  = sync_r[IRQ_SYNC-1][0];
        mip_s[9]  = mip_sw_i[9];
        mip_s[5]  = mip_sw_i[5];
        mip_s[1]  = mip_sw_i[1];
    end

    assign unused_s = ^{mip_sw_i[11:10], mip_sw_i[8:6], mip_sw_i[4:2], mip_sw_i[0]};

    // Pick the highest-priority takeable interrupt.
    always_comb begin
        irq_hit_s   = 1'b0;
        irq_cause_s = 4'd0;
        pend_s      = mip_s & mie_i;
        for (int k = 0; k < 6; k++) begin
            if (irq_takeable(pend_s[IRQ_ORDER[k]], HAS_SMODE && mideleg_i[IRQ_ORDER[k]],
                             priv_i, mstatus_mie_i, mstatus_sie_i)) begin
                irq_hit_s   = 1'b1;
                irq_cause_s = IRQ_ORDER[k];
            end else begin
                irq_hit_s   = irq_hit_s;
                irq_cause_s = irq_cause_s;
            end
        end
    end

    // Resolve exception cause/tval; returns not permitted at this privilege become illegal.
    always_comb begin
        ill_s = commit_exc_i[EXC_ILLEGAL] || commit_exc_i[EXC_URET]
             || (commit_exc_i[EXC_MRET] && (priv_i != PRIV_M))
             || (commit_exc_i[EXC_SRET] && ((priv_i == PRIV_U) || !HAS_SMODE));
        mret_ok_s   = commit_exc_i[EXC_MRET] && (priv_i == PRIV_M);
        sret_ok_s   = commit_exc_i[EXC_SRET] && (priv_i != PRIV_U) && HAS_SMODE;
        exc_hit_s   = 1'b1;
        exc_cause_s = 4'd0;
        exc_tval_s  = commit_tval_i;
        if (commit_exc_i[EXC_BKPT]) begin
            exc_cause_s = 4'd3;
            exc_tval_s  = commit_pc_i;
        end else if (commit_exc_i[EXC_FETCH_PF]) begin
            exc_cause_s = 4'd12;
        end else if (commit_exc_i[EXC_FETCH_AF]) begin
            exc_cause_s = 4'd1;
        end else if (ill_s) begin
            exc_cause_s = 4'd2;
            exc_tval_s  = commit_exc_i[EXC_ILLEGAL] ? commit_tval_i : {XLEN{1'b0}};
        end else if (commit_exc_i[EXC_FETCH_MIS]) begin
            exc_cause_s = 4'd0;
        end else if (commit_exc_i[EXC_ECALL]) begin
            exc_cause_s = 4'd8 + {2'd0, priv_i};
            exc_tval_s  = {XLEN{1'b0}};
        end else if (commit_exc_i[EXC_STORE_MIS]) begin
            exc_cause_s = 4'd6;
        end else if (commit_exc_i[EXC_LOAD_MIS]) begin
            exc_cause_s = 4'd4;
        end else if (commit_exc_i[EXC_STORE_PF]) begin
            exc_cause_s = 4'd15;
        end else if (commit_exc_i[EXC_LOAD_PF]) begin
            exc_cause_s = 4'd13;
        end else if (commit_exc_i[EXC_STORE_AF]) begin
            exc_cause_s = 4'd7;
        end else if (commit_exc_i[EXC_LOAD_AF]) begin
            exc_cause_s = 4'd5;
        end else begin
            exc_hit_s  = 1'b0;
            exc_tval_s = {XLEN{1'b0}};
        end
    end

    // Final selection: interrupt, then exception, then a legal xRET.
    always_comb begin
        ev_kind_s  = KIND_EXC;
        ev_cause_s = 4'd0;
        ev_tval_s  = {XLEN{1'b0}};
        ev_priv_s  = PRIV_M;
        if (irq_hit_s) begin
            ev_kind_s  = KIND_IRQ;
            ev_cause_s = irq_cause_s;
            ev_priv_s  = (HAS_SMODE && (priv_i <= PRIV_S) && mideleg_i[irq_cause_s]) ? PRIV_S : PRIV_M;
        end else if (exc_hit_s) begin
            ev_kind_s  = KIND_EXC;
            ev_cause_s = exc_cause_s;
            ev_tval_s  = exc_tval_s;
            ev_priv_s  = (HAS_SMODE && (priv_i <= PRIV_S) && medeleg_i[exc_cause_s]) ? PRIV_S : PRIV_M;
        end else if (mret_ok_s) begin
            ev_kind_s  = KIND_XRET;
            ev_priv_s  = PRIV_M;
        end else if (sret_ok_s) begin
            ev_kind_s  = KIND_XRET;
            ev_priv_s  = PRIV_S;
        end else begin
            ev_kind_s  = KIND_EXC;
        end
        ev_s = commit_valid_i && (irq_hit_s || exc_hit_s || mret_ok_s || sret_ok_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stall is raised in the detecting cycle itself.
    always_comb begin
        state_s = state_r;
        latch_s = 1'b0;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ev_s) begin
                    state_s = REQ;
                    latch_s = 1'b1;
                    stall_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (trap_ready_i) begin
                    state_s = FLUSH;
                end else begin
                    state_s = REQ;
                end
            end
            FLUSH: begin
                stall_s = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_valid_r <= 1'b0;
            flush_r      <= 1'b0;
        end else begin
            trap_valid_r <= (state_s == REQ);
            flush_r      <= (state_s == FLUSH);
        end
    end

    // Payload capture; frozen for the whole request regardless of commit inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_r  <= 2'd0;
            cause_r <= 4'd0;
            tval_r  <= {XLEN{1'b0}};
            epc_r   <= {XLEN{1'b0}};
            priv_r  <= 2'd0;
        end else if (latch_s) begin
            kind_r  <= ev_kind_s;
            cause_r <= ev_cause_s;
            tval_r  <= ev_tval_s;
            epc_r   <= commit_pc_i;
            priv_r  <= ev_priv_s;
        end
    end

    assign mip_o        = mip_s;
    assign stall_o      = stall_s;
    assign trap_valid_o = trap_valid_r;
    assign flush_o      = flush_r;
    assign trap_kind_o  = kind_r;
    assign trap_cause_o = cause_r;
    assign trap_tval_o  = tval_r;
    assign trap_epc_o   = epc_r;
    assign trap_priv_o  = priv_r;

endmodule

// File: tb/tb_trap_arbiter.sv
// Directed plus randomized bench for trap_arbiter against a priority-table reference model.
module tb_trap_arbiter;

    logic        clk;
    logic        rst_n;
    logic        commit_valid_i;
    logic [14:0] commit_exc_i;
    logic [63:0] commit_pc_i;
    logic [63:0] commit_tval_i;
    logic [1:0]  priv_i;
    logic        mstatus_mie_i;
    logic        mstatus_sie_i;
    logic [11:0] mie_i;
    logic [11:0] mideleg_i;
    logic [15:0] medeleg_i;
    logic [11:0] mip_sw_i;
    logic        irq_mext_i;
    logic        irq_msw_i;
    logic        irq_mtimer_i;
    logic [11:0] mip_o;
    logic        stall_o;
    logic        trap_valid_o;
    logic        trap_ready_i;
    logic [1:0]  trap_kind_o;
    logic [3:0]  trap_cause_o;
    logic [63:0] trap_tval_o;
    logic [63:0] trap_epc_o;
    logic [1:0]  trap_priv_o;
    logic        flush_o;

    int checks = 0;
    int errors = 0;

    // Priority tables: interrupt ids, and (flag bit, cause) pairs for exceptions.
    localparam int IRQ_RANK [6]  = '{11, 3, 7, 9, 1, 5};
    localparam int EXC_BIT  [12] = '{0, 13, 14, 1, 8, 5, 6, 7, 9, 11, 10, 12};
    localparam int EXC_CODE [12] = '{3, 12, 1, 2, 0, 8, 6, 4, 15, 13, 7, 5};

    trap_arbiter #(.XLEN(64), .HAS_SMODE(1'b1), .IRQ_SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_i(commit_valid_i), .commit_exc_i(commit_exc_i),
        .commit_pc_i(commit_pc_i), .commit_tval_i(commit_tval_i),
        .priv_i(priv_i), .mstatus_mie_i(mstatus_mie_i), .mstatus_sie_i(mstatus_sie_i),
        .mie_i(mie_i), .mideleg_i(mideleg_i), .medeleg_i(medeleg_i), .mip_sw_i(mip_sw_i),
        .irq_mext_i(irq_mext_i), .irq_msw_i(irq_msw_i), .irq_mtimer_i(irq_mtimer_i),
        .mip_o(mip_o), .stall_o(stall_o), .trap_valid_o(trap_valid_o),
        .trap_ready_i(trap_ready_i), .trap_kind_o(trap_kind_o), .trap_cause_o(trap_cause_o),
        .trap_tval_o(trap_tval_o), .trap_epc_o(trap_epc_o), .trap_priv_o(trap_priv_o),
        .flush_o(flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_mip();
        logic [11:0] m;
        m = mip_sw_i & 12'h222;
        m[11] = irq_mext_i;
        m[7]  = irq_mtimer_i;
        m[3]  = irq_msw_i;
        return m;
    endfunction

    // Expected trap for the current inputs, assuming the interrupt lines have settled.
    function automatic void model(output logic ev, output logic [1:0] k, output logic [3:0] c,
                                  output logic [63:0] t, output logic [1:0] p);
        logic [11:0] pend;
        logic [14:0] eff;
        logic        found;
        logic        ok;
        int          i;
        int          code;
        ev = 1'b0; k = 2'd0; c = 4'd0; t = 64'd0; p = 2'd0; found = 1'b0;
        pend = exp_mip() & mie_i;
        for (int r = 0; r < 6; r++) begin
            i = IRQ_RANK[r];
            ok = mideleg_i[i] ? ((priv_i == 2'd0) || (priv_i == 2'd1 && mstatus_sie_i))
                              : ((priv_i != 2'd3) || mstatus_mie_i);
            if (!found && pend[i] && ok) begin
                found = 1'b1; k = 2'd1; c = 4'(i);
                p = (mideleg_i[i] && priv_i <= 2'd1) ? 2'd1 : 2'd3;
            end
        end
        eff = commit_exc_i;
        if (commit_exc_i[2] || (commit_exc_i[4] && priv_i != 2'd3) || (commit_exc_i[3] && priv_i == 2'd0))
            eff[1] = 1'b1;
        for (int r = 0; r < 12; r++) begin
            if (!found && eff[EXC_BIT[r]]) begin
                found = 1'b1; k = 2'd0;
                code = EXC_CODE[r];
                if (code == 8) code = 8 + int'(priv_i);
                c = 4'(code);
                if (code == 3) t = commit_pc_i;
                else if (code >= 8 && code <= 11) t = 64'd0;
                else if (code == 2 && !commit_exc_i[1]) t = 64'd0;
                else t = commit_tval_i;
                p = (priv_i <= 2'd1 && medeleg_i[code]) ? 2'd1 : 2'd3;
            end
        end
        if (!found && commit_exc_i[4] && priv_i == 2'd3) begin
            found = 1'b1; k = 2'd2; c = 4'd0; t = 64'd0; p = 2'd3;
        end
        if (!found && commit_exc_i[3] && priv_i != 2'd0) begin
            found = 1'b1; k = 2'd2; c = 4'd0; t = 64'd0; p = 2'd1;
        end
        ev = found && commit_valid_i;
    endfunction

    task automatic clear_inputs();
        commit_valid_i = 1'b0; commit_exc_i = 15'd0; commit_pc_i = 64'd0; commit_tval_i = 64'd0;
        priv_i = 2'd3; mstatus_mie_i = 1'b0; mstatus_sie_i = 1'b0;
        mie_i = 12'd0; mideleg_i = 12'd0; medeleg_i = 16'd0; mip_sw_i = 12'd0;
        irq_mext_i = 1'b0; irq_msw_i = 1'b0; irq_mtimer_i = 1'b0; trap_ready_i = 1'b0;
    endtask

    // Commit inputs already driven in IDLE; walks detect, REQ (delay ready-low cycles), FLUSH.
    task automatic do_trap(input string tag, input logic exp_ev, input logic [1:0] ek, input logic [3:0] ec,
                           input logic [63:0] et, input logic [1:0] ep, input int delay);
        logic [63:0] epc_exp;
        epc_exp = commit_pc_i;
        #1;
        chk(tag, "stall_detect", stall_o, exp_ev);
        if (!exp_ev) begin
            commit_valid_i = 1'b0;
            step();
            chk(tag, "no_valid", trap_valid_o, 1'b0);
        end else begin
            step();
            for (int d = 0; d <= delay; d++) begin
                chk(tag, "valid", trap_valid_o, 1'b1);
                chk(tag, "kind", trap_kind_o, ek);
                chk(tag, "cause", trap_cause_o, ec);
                chk(tag, "tval", trap_tval_o, et);
                chk(tag, "epc", trap_epc_o, epc_exp);
                chk(tag, "priv", trap_priv_o, ep);
                chk(tag, "stall_req", stall_o, 1'b1);
                chk(tag, "flush_req", flush_o, 1'b0);
                if (d < delay) begin
                    commit_valid_i = 1'($urandom);
                    commit_exc_i   = 15'($urandom);
                    commit_pc_i    = {$urandom, $urandom};
                    commit_tval_i  = {$urandom, $urandom};
                end else begin
                    commit_valid_i = 1'b0;
                    trap_ready_i   = 1'b1;
                end
                step();
            end
            trap_ready_i = 1'b0;
            chk(tag, "flush", flush_o, 1'b1);
            chk(tag, "valid_flush", trap_valid_o, 1'b0);
            chk(tag, "stall_flush", stall_o, 1'b1);
            step();
            chk(tag, "flush_end", flush_o, 1'b0);
            chk(tag, "stall_end", stall_o, 1'b0);
        end
    endtask

    logic        m_ev;
    logic [1:0]  m_k;
    logic [3:0]  m_c;
    logic [63:0] m_t;
    logic [1:0]  m_p;

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #2 rst_n = 1'b0;
        #10;
        chk("reset", "mip", mip_o, 12'd0);
        chk("reset", "stall", stall_o, 1'b0);
        chk("reset", "valid", trap_valid_o, 1'b0);
        chk("reset", "flush", flush_o, 1'b0);
        chk("reset", "kind", trap_kind_o, 2'd0);
        chk("reset", "cause", trap_cause_o, 4'd0);
        chk("reset", "tval", trap_tval_o, 64'd0);
        chk("reset", "epc", trap_epc_o, 64'd0);
        chk("reset", "priv", trap_priv_o, 2'd0);
        step();
        rst_n = 1'b1;
        step();

        // ecall from U, delegated to S
        priv_i = 2'd0; medeleg_i = 16'h0100; commit_exc_i = 15'h0020;
        commit_pc_i = 64'h1000; commit_tval_i = 64'h55; commit_valid_i = 1'b1;
        do_trap("ecall_u", 1'b1, 2'd0, 4'd8, 64'd0, 2'd1, 0);

        // illegal beats load page fault
        clear_inputs();
        commit_exc_i = 15'h0802; commit_tval_i = 64'hDEAD; commit_pc_i = 64'h2000; commit_valid_i = 1'b1;
        do_trap("illegal_lpf", 1'b1, 2'd0, 4'd2, 64'hDEAD, 2'd3, 0);

        // timer line: two-cycle sync, masked at M with MIE=0, taken at U
        clear_inputs();
        mie_i = 12'h080; irq_mtimer_i = 1'b1;
        step();
        chk("sync", "mip_1cyc", mip_o[7], 1'b0);
        step();
        chk("sync", "mip_2cyc", mip_o[7], 1'b1);
        commit_valid_i = 1'b1; commit_pc_i = 64'h3000;
        do_trap("mti_masked", 1'b0, 2'd0, 4'd0, 64'd0, 2'd0, 0);
        priv_i = 2'd0; commit_valid_i = 1'b1; commit_pc_i = 64'h3004;
        do_trap("mti_u", 1'b1, 2'd1, 4'd7, 64'd0, 2'd3, 0);

        // MEI over MTI over breakpoint
        irq_mext_i = 1'b1; mie_i = 12'h880;
        step(); step();
        commit_exc_i = 15'h0001; commit_valid_i = 1'b1; commit_pc_i = 64'h3008;
        do_trap("mei_bkpt", 1'b1, 2'd1, 4'd11, 64'd0, 2'd3, 0);

        // mret at S is illegal; sret at S returns from S
        clear_inputs();
        step(); step();
        priv_i = 2'd1; commit_exc_i = 15'h0010; commit_tval_i = 64'h77; commit_valid_i = 1'b1;
        do_trap("mret_s", 1'b1, 2'd0, 4'd2, 64'd0, 2'd3, 0);
        priv_i = 2'd1; commit_exc_i = 15'h0008; commit_valid_i = 1'b1;
        do_trap("sret_s", 1'b1, 2'd2, 4'd0, 64'd0, 2'd1, 0);

        // ready held low for 5 cycles with commit inputs toggling
        clear_inputs();
        commit_exc_i = 15'h0020; commit_pc_i = 64'h4000; commit_valid_i = 1'b1;
        do_trap("hold5", 1'b1, 2'd0, 4'd11, 64'd0, 2'd3, 5);
        step();
        chk("hold5", "single_flush", flush_o, 1'b0);

        // reset mid-REQ
        clear_inputs();
        commit_exc_i = 15'h0001; commit_pc_i = 64'h5000; commit_valid_i = 1'b1;
        step();
        commit_valid_i = 1'b0;
        chk("rst_req", "valid_before", trap_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_req", "valid", trap_valid_o, 1'b0);
        chk("rst_req", "stall", stall_o, 1'b0);
        chk("rst_req", "flush", flush_o, 1'b0);
        chk("rst_req", "cause", trap_cause_o, 4'd0);
        chk("rst_req", "epc", trap_epc_o, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_req", "no_flush", flush_o, 1'b0);
        chk("rst_req", "idle", trap_valid_o, 1'b0);

        // randomized transactions against the model
        for (int n = 0; n < 200; n++) begin
            int sel;
            commit_valid_i = 1'b0;
            sel = $urandom_range(0, 2);
            priv_i = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd1 : 2'd3;
            mstatus_mie_i = 1'($urandom); mstatus_sie_i = 1'($urandom);
            mie_i = 12'($urandom); mideleg_i = 12'($urandom); medeleg_i = 16'($urandom);
            mip_sw_i = 12'($urandom) & 12'($urandom);
            irq_mext_i = ($urandom_range(0, 3) == 0); irq_msw_i = ($urandom_range(0, 3) == 0);
            irq_mtimer_i = ($urandom_range(0, 3) == 0);
            step(); step(); step();
            chk("rand", "mip", mip_o, exp_mip());
            sel = $urandom_range(0, 3);
            if (sel == 0) commit_exc_i = 15'd0;
            else if (sel == 1) commit_exc_i = 15'd1 << $urandom_range(0, 14);
            else if (sel == 2) commit_exc_i = (15'd1 << $urandom_range(0, 14)) | (15'd1 << $urandom_range(0, 14));
            else commit_exc_i = 15'($urandom);
            commit_pc_i = {$urandom, $urandom}; commit_tval_i = {$urandom, $urandom};
            commit_valid_i = ($urandom_range(0, 3) != 0);
            model(m_ev, m_k, m_c, m_t, m_p);
            do_trap("rand", m_ev, m_k, m_c, m_t, m_p, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Commit-stage trap arbiter that replaces the flat exception-flag bundle with a sequential trap controller. It synchronises interrupt lines and resolves the highest-priority exception, interrupt or xRET for the committing instruction. It computes the RISC-V cause, tval, epc and target privilege, with delegation and privilege checks, then holds the pipeline while it hands one trap request to the CSR unit and issues a single-cycle flush.

## Interface
- XLEN, 64, datapath width of pc/tval/epc.
- HAS_SMODE, 1, 0 forces every trap to M and makes sret illegal.
- IRQ_SYNC, 2, flop stages on the asynchronous interrupt lines (>=1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- commit_valid_i  in  1  instruction at commit.
- commit_exc_i  in  15  flags, MSB..LSB: fetch_access_fault, fetch_pagefault, load_access_fault, load_pagefault, store_access_fault, store_pagefault, fetch_misalign, load_misalign, store_misalign, ecall, mret, sret, uret, illegal_inst, breakpoint.
- commit_pc_i  in  XLEN  pc of committing instruction.
- commit_tval_i  in  XLEN  faulting address, or instruction bits for illegal_inst.
- priv_i  in  2  current privilege (0 U, 1 S, 3 M).
- mstatus_mie_i, mstatus_sie_i  in  1 each  global enables.
- mie_i, mideleg_i  in  12 each  interrupt enable / delegation.
- medeleg_i  in  16  exception delegation.
- mip_sw_i  in  12  CSR-writable pending bits (only 1, 5, 9 used).
- irq_mext_i, irq_msw_i, irq_mtimer_i  in  1 each  asynchronous interrupt lines.
- mip_o  out  12  merged pending vector (bits 3, 7, 11 from synchronised lines).
- stall_o  out  1  hold pipeline.
- trap_valid_o  out  1  request to CSR unit.
- trap_ready_i  in  1  CSR unit accepts.
- trap_kind_o  out  2  0 exception, 1 interrupt, 2 xRET.
- trap_cause_o  out  4  cause code (xRET: 0).
- trap_tval_o, trap_epc_o  out  XLEN each.
- trap_priv_o  out  2  target privilege (xRET: privilege being returned from).
- flush_o  out  1  one-cycle pipeline flush.

## Operation
- FSM states: IDLE, REQ, FLUSH.
- IDLE: an event exists when commit_valid_i=1 and any interrupt is takeable or any flag is set. Event -> latch payload, go to REQ.
- REQ: trap_valid_o=1 with the payload held stable; stay until trap_ready_i=1, then go to FLUSH.
- FLUSH: flush_o=1 for one cycle, then go to IDLE.
- Selection order: interrupt > exception > xRET.
- Interrupt order: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5). Pending = mip_o & mie_i.
- Non-delegated interrupt is takeable if priv<M, or priv=M and mstatus_mie_i=1.
- Delegated interrupt (mideleg set, HAS_SMODE) is takeable if priv=U, or priv=S and mstatus_sie_i=1; never at M.
- Exception order / cause:
  - breakpoint 3 > fetch_pagefault 12 > fetch_access_fault 1 > illegal 2 > fetch_misalign 0 > ecall 8+priv_i
  - > store_misalign 6 > load_misalign 4 > store_pagefault 15 > load_pagefault 13 > store_access_fault 7 > load_access_fault 5.
- Privilege-illegal returns become illegal (cause 2, tval 0):
  - uret always;
  - mret when priv<M;
  - sret when priv=U or HAS_SMODE=0.
- A legal mret/sret with no other flag is kind 2.
- Target privilege: S if HAS_SMODE, priv_i<=S and the medeleg/mideleg bit for the cause is set; else M.
- tval:
  - commit_tval_i for fault, misalign and illegal_inst causes;
  - commit_pc_i for breakpoint;
  - 0 for ecall, interrupt and xRET.
- epc = commit_pc_i in all cases (interrupt: instruction not retired).
- commit_valid_i is ignored outside IDLE.

## Timing
- Reset: state IDLE, all outputs 0, sync flops 0; reset mid-REQ/FLUSH drops the request without flush.
- stall_o is combinational in the detecting IDLE cycle, and 1 throughout REQ and FLUSH.
- Event at cycle N -> trap_valid_o from N+1; ready at cycle M -> flush_o at M+1; IDLE at M+2 (next event accepted at M+2).
- Minimum trap-to-trap spacing is 3 cycles.
- Interrupt line change is visible on mip_o after exactly IRQ_SYNC cycles.
- Payload is frozen from N+1 until leaving REQ, even if inputs change.

## Test plan
- priv=U, ecall only, medeleg[8]=1, ready held 1 -> valid at N+1, kind 0, cause 8, priv_o 1, tval 0, flush at N+2.
- priv=M, illegal_inst+load_pagefault, tval=0xDEAD -> cause 2, priv_o 3, tval 0xDEAD.
- irq_mtimer_i rises with mie[7]=1, MIE=0 at priv M -> no trap; priv U, commit_valid after 2 cycles -> kind 1, cause 7, epc=commit_pc.
- MEI and MTI pending plus a breakpoint flag -> kind 1, cause 11.
- mret at priv S -> cause 2; sret at S -> kind 2, priv_o 1.
- trap_ready_i low for 5 cycles with commit inputs toggling -> payload stable; stall_o held; one flush only; reset pulse mid-REQ -> all outputs 0.
